// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button front end.
// Optional feature macro used by this slice: BTN_AUTOREPEAT_EN (per-channel auto-repeat).
package btn_pkg;

  // Arbiter states: waiting for a pending press, or holding an offered event.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  // Smallest debounce window the channel logic supports.
  localparam int MIN_DEB_CYCLES = 1;

  // Width of a channel index; a single channel still gets one bit.
  function automatic int btn_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, debounce counter, debounced level,
// one-cycle press pulse on a debounced rising edge and, when the
// BTN_AUTOREPEAT_EN macro is defined, a periodic repeat pulse while held.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  // A window below the minimum is treated as the minimum.
  localparam int DEB_EFF = (DEB_CYCLES < MIN_DEB_CYCLES) ? MIN_DEB_CYCLES : DEB_CYCLES;
  localparam int CNT_W = $clog2(DEB_EFF + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] deb_cnt_r;
  logic             level_r;
  logic             rise_r;

  // Two-stage synchroniser for the asynchronous raw button level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: the level follows the synchronised input only after it has
  // disagreed for DEB_EFF consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_r <= {CNT_W{1'b0}};
      level_r   <= 1'b0;
      rise_r    <= 1'b0;
    end else if (sync2_r != level_r) begin
      if (deb_cnt_r == DEB_LAST) begin
        level_r   <= sync2_r;
        deb_cnt_r <= {CNT_W{1'b0}};
        rise_r    <= sync2_r;
      end else begin
        deb_cnt_r <= deb_cnt_r + CNT_ONE;
        rise_r    <= 1'b0;
      end
    end else begin
      deb_cnt_r <= {CNT_W{1'b0}};
      rise_r    <= 1'b0;
    end
  end

  assign level = level_r;

  // A non-positive repeat period leaves auto-repeat off even when enabled.
  if (AUTOREPEAT && (REPEAT_CYCLES > 0)) begin : g_repeat
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic [REP_W-1:0] rep_cnt_r;
    logic             rep_r;

    // Repeat timer: idle while released, restarts with the debounced press
    // (level was 0 on that cycle) and fires once every REPEAT_CYCLES while held.
    always_ff @(posedge clk) begin
      if (rst) begin
        rep_cnt_r <= {REP_W{1'b0}};
        rep_r     <= 1'b0;
      end else if (!level_r) begin
        rep_cnt_r <= {REP_W{1'b0}};
        rep_r     <= 1'b0;
      end else if (rep_cnt_r == REP_LAST) begin
        rep_cnt_r <= {REP_W{1'b0}};
        rep_r     <= 1'b1;
      end else begin
        rep_cnt_r <= rep_cnt_r + REP_ONE;
        rep_r     <= 1'b0;
      end
    end

    assign press = rise_r | rep_r;
  end else begin : g_no_repeat
    assign press = rise_r;
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Push-button front end: N_BTN debounced channels feeding pending-press bits,
// shared by round-robin onto one valid/ready event port.
// Optional feature macro: BTN_AUTOREPEAT_EN (auto-repeat while a button is held).
module button_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int DEB_CYCLES    = 500000,
  parameter int REPEAT_CYCLES = 25000000,
  localparam int IDX_W        = btn_idx_w(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDX_W-1:0] evt_idx_o,
  output logic [N_BTN-1:0] level_o,
  output logic             overrun_o
);

  logic [N_BTN-1:0] level_s;
  logic [N_BTN-1:0] press_s;
  logic [N_BTN-1:0] clr_s;
  logic [N_BTN-1:0] pending_r;
  logic             overrun_r;
  logic             accept_s;
  logic [IDX_W-1:0] grant_s;
  logic             grant_found_s;
  int               cand_s;
  arb_state_t       state_r;
  logic             evt_valid_r;
  logic [IDX_W-1:0] evt_idx_r;
  logic [IDX_W-1:0] last_grant_r;

  for (genvar k = 0; k < N_BTN; k++) begin : g_chan
    btn_debounce #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_i[k]),
      .level(level_s[k]),
      .press(press_s[k])
    );
  end

  // Handshake completes only while an event is actually being offered.
  assign accept_s = (state_r == ST_OFFER) && evt_valid_r && evt_ready_i;

  // One-hot clear of the channel whose event is accepted this cycle.
  always_comb begin
    clr_s = {N_BTN{1'b0}};
    for (int k = 0; k < N_BTN; k++) begin
      clr_s[k] = accept_s && (evt_idx_r == IDX_W'(k));
    end
  end

  // Pending bits: a new press wins over a same-cycle clear; a press onto an
  // already pending (and not clearing) channel is lost and flagged as overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {N_BTN{1'b0}};
      overrun_r <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~clr_s) | press_s;
      overrun_r <= |(press_s & pending_r & ~clr_s);
    end
  end

  // Round-robin pick: first pending channel after the last granted one.
  always_comb begin
    grant_s       = {IDX_W{1'b0}};
    grant_found_s = 1'b0;
    cand_s        = 0;
    for (int i = 1; i <= N_BTN; i++) begin
      cand_s        = (int'(last_grant_r) + i) % N_BTN;
      grant_s       = (!grant_found_s && pending_r[cand_s]) ? IDX_W'(cand_s) : grant_s;
      grant_found_s = grant_found_s | pending_r[cand_s];
    end
  end

  // Event FSM: offer the granted channel, hold it stable until accepted,
  // then spend one idle cycle before the next offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      evt_valid_r  <= 1'b0;
      evt_idx_r    <= {IDX_W{1'b0}};
      last_grant_r <= IDX_W'(N_BTN - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|pending_r) begin
            evt_idx_r   <= grant_s;
            evt_valid_r <= 1'b1;
            state_r     <= ST_OFFER;
          end else begin
            evt_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        ST_OFFER: begin
          if (evt_ready_i) begin
            last_grant_r <= evt_idx_r;
            evt_valid_r  <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            evt_valid_r  <= 1'b1;
            state_r      <= ST_OFFER;
          end
        end
        default: begin
          evt_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign evt_valid_o = evt_valid_r;
  assign evt_idx_o   = evt_idx_r;
  assign level_o     = level_s;
  assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter (N_BTN=4, DEB_CYCLES=4, REPEAT_CYCLES=16).
module tb_button_event_arbiter;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int REP = 16;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_i = 4'h0;
  logic       evt_ready_i = 1'b1;
  logic       evt_valid_o;
  logic [1:0] evt_idx_o;
  logic [3:0] level_o;
  logic       overrun_o;

  always #5 clk = ~clk;

  button_event_arbiter #(.N_BTN(N), .DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst), .btn_i(btn_i), .evt_valid_o(evt_valid_o),
    .evt_ready_i(evt_ready_i), .evt_idx_o(evt_idx_o), .level_o(level_o), .overrun_o(overrun_o)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] m_d1 = '0, m_d2 = '0, m_lvl = '0, m_press = '0, m_pend = '0;
  int         m_run[4];
  int         m_hc[4];
  logic       m_valid = 1'b0, m_ovr = 1'b0;
  logic [1:0] m_idx = '0;
  int         m_last = N - 1;

  // observation
  int   cyc = 0;
  int   acc_idx[$];
  int   rise_cyc[$];
  int   ovr_count = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic       ready;
    logic       e_valid;
    logic [1:0] e_idx;
    logic [3:0] e_level;
    logic       e_ovr;
  } vec_t;
  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [3:0] clr;
    logic [3:0] npress;
    int g;
    bit found;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_press = '0; m_pend = '0;
      m_valid = 1'b0; m_idx = '0; m_last = N - 1; m_ovr = 1'b0;
      for (int k = 0; k < N; k++) begin m_run[k] = 0; m_hc[k] = 0; end
      return;
    end
    clr = '0;
    if (m_valid && evt_ready_i) clr[m_idx] = 1'b1;
    m_ovr = |(m_press & m_pend & ~clr);
    if (m_valid && evt_ready_i) begin
      m_valid = 1'b0;
      m_last  = int'(m_idx);
    end else if (!m_valid && m_pend != 4'h0) begin
      found = 0; g = 0;
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (!found && m_pend[c]) begin found = 1; g = c; end
      end
      m_valid = 1'b1;
      m_idx   = 2'(g);
    end
    m_pend = (m_pend & ~clr) | m_press;
    npress = '0;
    for (int k = 0; k < N; k++) begin
      // time held since the debounced press; a press every REP cycles
      if (m_lvl[k]) begin
        m_hc[k]++;
        if (m_hc[k] == REP) begin npress[k] = AR; m_hc[k] = 0; end
      end else begin
        m_hc[k] = 0;
      end
      // level follows input after DEB consecutive cycles of disagreement
      if (m_d2[k] != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == DEB) begin
          m_lvl[k] = m_d2[k];
          m_run[k] = 0;
          if (m_d2[k]) npress[k] = 1'b1;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = btn_i;
    m_press = npress;
  endtask

  task automatic step();
    if (evt_valid_o === 1'b1 && evt_ready_i === 1'b1 && !rst) acc_idx.push_back(int'(evt_idx_o));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    if (overrun_o === 1'b1) ovr_count++;
    if (evt_valid_o === 1'b1 && !prev_valid) rise_cyc.push_back(cyc);
    prev_valid = evt_valid_o;
    check("model_level", 32'(level_o), 32'(m_lvl));
    check("model_valid", 32'(evt_valid_o), 32'(m_valid));
    if (m_valid) check("model_idx", 32'(evt_idx_o), 32'(m_idx));
    check("model_overrun", 32'(overrun_o), 32'(m_ovr));
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_i = 4'h0;
    step();
    rst = 1'b0;
    cyc = 0;
    acc_idx.delete();
    rise_cyc.delete();
    ovr_count = 0;
  endtask

  initial begin
    int exp_rise[$];
    for (int k = 0; k < N; k++) begin m_run[k] = 0; m_hc[k] = 0; end

    // single press on channel 2, then release
    tbl[0] = '{1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[1] = '{1'b1, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    for (int i = 2; i <= 6; i++) tbl[i] = '{1'b0, 4'h4, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 4'h4, 1'b1, 1'b0, 2'd0, 4'h4, 1'b0};
    tbl[8]  = '{1'b0, 4'h4, 1'b1, 1'b0, 2'd0, 4'h4, 1'b0};
    tbl[9]  = '{1'b0, 4'h4, 1'b1, 1'b1, 2'd2, 4'h4, 1'b0};
    tbl[10] = '{1'b0, 4'h4, 1'b1, 1'b0, 2'd0, 4'h4, 1'b0};
    tbl[11] = '{1'b0, 4'h4, 1'b1, 1'b0, 2'd0, 4'h4, 1'b0};
    for (int i = 12; i <= 16; i++) tbl[i] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h4, 1'b0};
    tbl[17] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};

    @(negedge clk);
    acc_idx.delete();
    for (int i = 0; i < 18; i++) begin
      rst = tbl[i].rst; btn_i = tbl[i].btn; evt_ready_i = tbl[i].ready;
      step();
      check($sformatf("tbl%0d_valid", i), 32'(evt_valid_o), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) check($sformatf("tbl%0d_idx", i), 32'(evt_idx_o), 32'(tbl[i].e_idx));
      check($sformatf("tbl%0d_level", i), 32'(level_o), 32'(tbl[i].e_level));
      check($sformatf("tbl%0d_overrun", i), 32'(overrun_o), 32'(tbl[i].e_ovr));
    end
    repeat (6) step();
    check("single_press_events", 32'(acc_idx.size()), 32'd1);

    // reset with all buttons held: outputs zero, then idx 0,1,2,3
    rst = 1'b1; btn_i = 4'hF; evt_ready_i = 1'b1;
    repeat (2) step();
    check("rst_valid", 32'(evt_valid_o), 32'd0);
    check("rst_idx", 32'(evt_idx_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    rst = 1'b0; acc_idx.delete();
    repeat (12) step();
    btn_i = 4'h0;
    repeat (18) step();
    check("rst_hold_events", 32'(acc_idx.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_idx.size(); i++)
      check($sformatf("rst_hold_idx%0d", i), 32'(acc_idx[i]), 32'(i));

    // glitch: 3-cycle pulse ignored, 4-cycle pulse gives one event
    do_reset();
    btn_i = 4'h2; repeat (3) step();
    btn_i = 4'h0; repeat (12) step();
    check("glitch3_events", 32'(acc_idx.size()), 32'd0);
    check("glitch3_level", 32'(level_o), 32'd0);
    btn_i = 4'h2; repeat (4) step();
    btn_i = 4'h0; repeat (16) step();
    check("pulse4_events", 32'(acc_idx.size()), 32'd1);
    if (acc_idx.size() > 0) check("pulse4_idx", 32'(acc_idx[0]), 32'd1);

    // round-robin: last grant 1, channels 1 and 3 pending -> 3 then 1
    do_reset();
    btn_i = 4'h2; repeat (10) step();
    btn_i = 4'h0; repeat (12) step();
    check("rr_prime_events", 32'(acc_idx.size()), 32'd1);
    evt_ready_i = 1'b0;
    btn_i = 4'hA; repeat (8) step();
    btn_i = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("rr_hold_valid", 32'(evt_valid_o), 32'd1);
      check("rr_hold_idx", 32'(evt_idx_o), 32'd3);
    end
    acc_idx.delete();
    evt_ready_i = 1'b1;
    repeat (6) step();
    check("rr_events", 32'(acc_idx.size()), 32'd2);
    if (acc_idx.size() == 2) begin
      check("rr_first", 32'(acc_idx[0]), 32'd3);
      check("rr_second", 32'(acc_idx[1]), 32'd1);
    end

    // overrun: second press while channel 0 still pending
    do_reset();
    evt_ready_i = 1'b0;
    btn_i = 4'h1; repeat (8) step();
    btn_i = 4'h0; repeat (10) step();
    btn_i = 4'h1; repeat (10) step();
    btn_i = 4'h0; repeat (10) step();
    check("overrun_pulses", 32'(ovr_count), 32'd1);
    evt_ready_i = 1'b1;
    repeat (6) step();
    check("overrun_events", 32'(acc_idx.size()), 32'd1);
    if (acc_idx.size() > 0) check("overrun_idx", 32'(acc_idx[0]), 32'd0);

    // hold channel 0 for 60 cycles: repeat events only with auto-repeat
    do_reset();
    if (AR) exp_rise = '{8, 24, 40, 56};
    else exp_rise = '{8};
    btn_i = 4'h1; repeat (60) step();
    btn_i = 4'h0; repeat (20) step();
    check("hold_event_count", 32'(rise_cyc.size()), 32'(exp_rise.size()));
    for (int i = 0; i < exp_rise.size() && i < rise_cyc.size(); i++)
      check($sformatf("hold_event%0d_cycle", i), 32'(rise_cyc[i]), 32'(exp_rise[i]));

    // random stimulus against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 9) == 0) btn_i[k] = ~btn_i[k];
      evt_ready_i = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 799) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
